// File: rtl/ac97_frame_engine.sv
// AC'97 link frame engine: 256-bit frame timing, command FIFO, serial slot
// transmit and capture of codec status and PCM input slots.
module ac97_frame_engine #(
  parameter int SAMPLE_WIDTH = 20,
  parameter int NUM_CH       = 2,
  parameter int CMD_DEPTH    = 4
) (
  input  logic                           ac97_bit_clock,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [7:0]                     cmd_addr,
  input  logic [15:0]                    cmd_data,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] out_data,
  input  logic [NUM_CH-1:0]              out_valid,
  output logic [NUM_CH*SAMPLE_WIDTH-1:0] in_data,
  output logic                           in_valid,
  output logic [7:0]                     status_addr,
  output logic [15:0]                    status_data,
  output logic                           status_valid,
  output logic                           frame_start,
  output logic                           ac97_synch,
  output logic                           ac97_sdata_out,
  input  logic                           ac97_sdata_in
);
  localparam int PW      = $clog2(CMD_DEPTH);
  localparam int CAP_LEN = 80;

  logic                           running;
  logic [7:0]                     bit_count;
  logic [7:0]                     cnt_next;
  logic                           frame_end;
  logic [23:0]                    mem [CMD_DEPTH];
  logic [PW-1:0]                  wr_ptr;
  logic [PW-1:0]                  rd_ptr;
  logic [PW:0]                    count;
  logic                           push;
  logic                           pop;
  logic [23:0]                    head;
  logic                           lat_cmd_valid;
  logic [7:0]                     lat_addr;
  logic [15:0]                    lat_data;
  logic [NUM_CH*SAMPLE_WIDTH-1:0] lat_samples;
  logic [NUM_CH-1:0]              lat_valid;
  logic [19:0]                    slot1;
  logic [19:0]                    slot2;
  logic [19:0]                    pcm_slot [NUM_CH];
  logic [255:0]                   frame_bits;
  logic [CAP_LEN-2:0]             cap;
  logic [CAP_LEN-1:0]             cap_next;
  logic                           unused_cap;

  // The first edge after reset parks the counter at 0 so frame 0 is a full frame.
  assign cnt_next  = running ? bit_count + 8'd1 : 8'd0;
  assign frame_end = (bit_count == 8'd255);
  assign cmd_ready = (count != (PW+1)'(CMD_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = frame_end && (count != '0);
  assign head      = mem[rd_ptr];
  assign cap_next  = {cap, ac97_sdata_in};
  assign unused_cap = ^cap_next;

  always_ff @(posedge ac97_bit_clock) begin
    if (push) mem[wr_ptr] <= {cmd_addr, cmd_data};
  end

  always_ff @(posedge ac97_bit_clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ac97_bit_clock or posedge reset) begin
    if (reset) begin
      lat_cmd_valid <= 1'b0;
      lat_addr      <= '0;
      lat_data      <= '0;
      lat_samples   <= '0;
      lat_valid     <= '0;
    end else if (frame_end) begin
      lat_cmd_valid <= pop;
      lat_addr      <= pop ? head[23:16] : 8'h00;
      lat_data      <= pop ? head[15:0] : 16'h0000;
      lat_samples   <= out_data;
      lat_valid     <= out_valid;
    end
  end

  // Whole outgoing frame indexed by bit position; position 0 leaves the pin first.
  always_comb begin
    frame_bits    = '0;
    frame_bits[0] = 1'b1;
    frame_bits[1] = lat_cmd_valid;
    frame_bits[2] = lat_cmd_valid && !lat_addr[7];
    slot1 = lat_cmd_valid ? {lat_addr, 12'h000} : 20'h00000;
    slot2 = (lat_cmd_valid && !lat_addr[7]) ? {lat_data, 4'h0} : 20'h00000;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      frame_bits[3+ch] = lat_valid[ch];
      pcm_slot[ch] = lat_valid[ch] ?
        (20'(lat_samples[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH]) << (20 - SAMPLE_WIDTH)) : 20'h00000;
    end
    for (int k = 0; k < 20; k++) begin
      frame_bits[16+k] = slot1[19-k];
      frame_bits[36+k] = slot2[19-k];
      for (int ch = 0; ch < NUM_CH; ch++) begin
        frame_bits[56+20*ch+k] = pcm_slot[ch][19-k];
      end
    end
  end

  always_ff @(posedge ac97_bit_clock or posedge reset) begin
    if (reset) begin
      running        <= 1'b0;
      bit_count      <= '0;
      ac97_synch     <= 1'b0;
      frame_start    <= 1'b0;
      ac97_sdata_out <= 1'b0;
    end else begin
      running        <= 1'b1;
      bit_count      <= cnt_next;
      ac97_synch     <= (cnt_next < 8'd16);
      frame_start    <= (cnt_next == 8'd0);
      ac97_sdata_out <= frame_bits[cnt_next];
    end
  end

  // cap_next[0] holds the bit of position bit_count-1; older bits sit higher.
  always_ff @(posedge ac97_bit_clock or posedge reset) begin
    if (reset) begin
      cap          <= '0;
      in_data      <= '0;
      in_valid     <= 1'b0;
      status_addr  <= '0;
      status_data  <= '0;
      status_valid <= 1'b0;
    end else begin
      cap          <= cap_next[CAP_LEN-2:0];
      in_valid     <= (cnt_next == 8'd137);
      status_valid <= (cnt_next == 8'd57) && cap_next[54];
      if ((cnt_next == 8'd57) && cap_next[54]) begin
        status_addr <= cap_next[39:32];
        status_data <= cap_next[19:4];
      end
      if (cnt_next == 8'd137) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          in_data[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= cap_next[79-20*ch -: SAMPLE_WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_ac97_frame_engine.sv
// Bench for ac97_frame_engine (16-bit samples, 4 channels): a frame-level model
// predicts every serial bit, pulse and captured value.
module tb_ac97_frame_engine;
  localparam int SW = 16;
  localparam int NCH = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_addr = 8'h00;
  logic [15:0] cmd_data = 16'h0000;
  logic [63:0] out_data = 64'h0;
  logic [3:0]  out_valid = 4'h0;
  logic [63:0] in_data;
  logic        in_valid;
  logic [7:0]  status_addr;
  logic [15:0] status_data;
  logic        status_valid;
  logic        frame_start;
  logic        ac97_synch;
  logic        ac97_sdata_out;
  logic        ac97_sdata_in = 1'b0;

  always #5 clk = ~clk;

  ac97_frame_engine #(.SAMPLE_WIDTH(SW), .NUM_CH(NCH), .CMD_DEPTH(DEPTH)) dut (
    .ac97_bit_clock(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .out_data(out_data), .out_valid(out_valid), .in_data(in_data), .in_valid(in_valid),
    .status_addr(status_addr), .status_data(status_data), .status_valid(status_valid),
    .frame_start(frame_start), .ac97_synch(ac97_synch),
    .ac97_sdata_out(ac97_sdata_out), .ac97_sdata_in(ac97_sdata_in)
  );

  int n_assert = 0;
  int n_fail = 0;

  logic [23:0]  q[$];
  logic [255:0] exp_frame, codec_bits, rx_bits, tx_bits;
  logic [63:0]  lat_smp;
  logic [3:0]   lat_v;
  logic [7:0]   exp_saddr;
  logic [15:0]  exp_sdata;
  logic         prev_out;
  int           cyc, pos;
  bit           have_pos, accepted, loop_mode, rand_codec, chk_loop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (frame pos %0d)", tag, obs, exp, pos);
    end
  endtask

  function automatic logic [255:0] put_slot(input logic [255:0] f, input int s, input logic [19:0] v);
    for (int b = 0; b < 20; b++) f[16+20*(s-1)+b] = v[19-b];
    return f;
  endfunction

  function automatic logic [19:0] get_slot(input logic [255:0] f, input int s);
    logic [19:0] v;
    for (int b = 0; b < 20; b++) v[19-b] = f[16+20*(s-1)+b];
    return v;
  endfunction

  function automatic logic [15:0] get_slot0(input logic [255:0] f);
    logic [15:0] v;
    for (int b = 0; b < 16; b++) v[15-b] = f[b];
    return v;
  endfunction

  function automatic logic [255:0] build(input logic cv, input logic [7:0] a, input logic [15:0] d,
                                         input logic [63:0] smp, input logic [3:0] v);
    logic [255:0] f;
    f = '0;
    f[0] = 1'b1;
    f[1] = cv;
    f[2] = cv && !a[7];
    for (int ch = 0; ch < NCH; ch++) f[3+ch] = v[ch];
    f = put_slot(f, 1, cv ? {a, 12'h000} : 20'h0);
    f = put_slot(f, 2, (cv && !a[7]) ? {d, 4'h0} : 20'h0);
    for (int ch = 0; ch < NCH; ch++)
      f = put_slot(f, 3 + ch, v[ch] ? {smp[16*ch +: 16], 4'h0} : 20'h0);
    return f;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    logic [23:0] c;
    logic        cv, ready_b, b;
    logic [19:0] s;
    logic [63:0] e;
    @(posedge clk);
    accepted = 0;
    ready_b = (q.size() < DEPTH);
    if (have_pos && pos == 255) begin
      cv = (q.size() > 0);
      c = cv ? q.pop_front() : 24'h0;
      lat_smp = out_data;
      lat_v = out_valid;
      exp_frame = build(cv, c[23:16], c[15:0], out_data, out_valid);
    end
    if (cmd_valid && ready_b) begin
      q.push_back({cmd_addr, cmd_data});
      accepted = 1;
    end
    #1;
    cyc++;
    pos = (cyc - 1) % 256;
    have_pos = 1;
    if (rand_codec && pos == 0) codec_bits = rand256();
    b = loop_mode ? prev_out : codec_bits[(pos + 255) % 256];
    ac97_sdata_in = b;
    rx_bits[(pos + 255) % 256] = b;
    prev_out = ac97_sdata_out;
    tx_bits[pos] = ac97_sdata_out;
    check("synch", 64'(ac97_synch), 64'(pos < 16));
    check("frame_start", 64'(frame_start), 64'(pos == 0));
    check("sdata_out", 64'(ac97_sdata_out), 64'(exp_frame[pos]));
    check("cmd_ready", 64'(cmd_ready), 64'(q.size() < DEPTH));
    check("in_valid", 64'(in_valid), 64'(pos == 137));
    check("status_valid", 64'(status_valid), 64'((pos == 57) && rx_bits[1]));
    if (pos == 57) begin
      if (rx_bits[1]) begin
        s = get_slot(rx_bits, 1);
        exp_saddr = s[19:12];
        s = get_slot(rx_bits, 2);
        exp_sdata = s[19:4];
      end
      check("status_addr", 64'(status_addr), 64'(exp_saddr));
      check("status_data", 64'(status_data), 64'(exp_sdata));
    end
    if (pos == 137) begin
      for (int ch = 0; ch < NCH; ch++) begin
        s = get_slot(rx_bits, 3 + ch);
        e[16*ch +: 16] = s[19:4];
      end
      check("in_data", in_data, e);
      if (chk_loop) begin
        for (int ch = 0; ch < NCH; ch++) e[16*ch +: 16] = lat_v[ch] ? lat_smp[16*ch +: 16] : 16'h0;
        check("loop_data", in_data, e);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_until(input int p);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (pos != p && k < 600);
    if (pos != p) check("run_until_timeout", 64'(pos), 64'(p));
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [15:0] d);
    int k;
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_data = d;
    k = 0;
    do begin
      step();
      k++;
    end while (!accepted && k < 1000);
    cmd_valid = 1'b0;
    if (!accepted) check("push_timeout", 64'(accepted), 64'(1));
    $display("push addr=%h data=%h accepted at frame pos %0d", a, d, (pos + 255) % 256);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check("rst_synch", 64'(ac97_synch), 64'(0));
    check("rst_sdata_out", 64'(ac97_sdata_out), 64'(0));
    check("rst_frame_start", 64'(frame_start), 64'(0));
    check("rst_in_data", in_data, 64'(0));
    check("rst_in_valid", 64'(in_valid), 64'(0));
    check("rst_status_addr", 64'(status_addr), 64'(0));
    check("rst_status_data", 64'(status_data), 64'(0));
    check("rst_status_valid", 64'(status_valid), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    q.delete();
    exp_frame = build(1'b0, 8'h0, 16'h0, 64'h0, 4'h0);
    exp_saddr = 8'h0;
    exp_sdata = 16'h0;
    rx_bits = '0;
    tx_bits = '0;
    lat_smp = '0;
    lat_v = '0;
    prev_out = 1'b0;
    cyc = 0;
    pos = 0;
    have_pos = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("reset released");
  endtask

  initial begin
    logic [19:0] s;
    loop_mode = 0; rand_codec = 0; chk_loop = 0;
    codec_bits = '0;
    #1;
    do_reset();

    // Idle frames: sync width, frame_start and the empty first frame.
    run(256);
    check("first_slot0", 64'(get_slot0(tx_bits)), 64'(16'h8000));
    run(256);
    $display("idle frames done");

    // Register write.
    run_until(100);
    push_cmd(8'h18, 16'h0808);
    run_until(255);
    run_until(255);
    check("wr_tags", 64'({tx_bits[0], tx_bits[1], tx_bits[2]}), 64'(3'b111));
    check("wr_slot1", 64'(get_slot(tx_bits, 1)), 64'(20'h18000));
    check("wr_slot2", 64'(get_slot(tx_bits, 2)), 64'(20'h08080));
    $display("write frame checked");

    // Register read with a codec status reply.
    run_until(100);
    push_cmd(8'h80, 16'hFFFF);
    codec_bits = '0;
    codec_bits[1] = 1'b1;
    codec_bits = put_slot(codec_bits, 1, {8'h80, 12'h000});
    codec_bits = put_slot(codec_bits, 2, {16'h1234, 4'h0});
    run_until(255);
    run_until(255);
    check("rd_tags", 64'({tx_bits[1], tx_bits[2]}), 64'(2'b10));
    check("rd_slot1", 64'(get_slot(tx_bits, 1)), 64'(20'h80000));
    check("rd_slot2", 64'(get_slot(tx_bits, 2)), 64'(20'h0));
    run_until(57);
    check("rd_status_pulse", 64'(status_valid), 64'(1));
    run_until(58);
    check("rd_status_addr", 64'(status_addr), 64'(8'h80));
    check("rd_status_data", 64'(status_data), 64'(16'h1234));
    codec_bits = '0;
    $display("read frame and status checked");

    // PCM slots with partial channel validity.
    run_until(100);
    out_valid = 4'b0101;
    out_data = {16'h2222, 16'h5A5A, 16'h1111, 16'hA5A5};
    run_until(255);
    run_until(255);
    s = get_slot(tx_bits, 3); check("pcm_slot3", 64'(s), 64'(20'hA5A50));
    s = get_slot(tx_bits, 4); check("pcm_slot4", 64'(s), 64'(20'h0));
    s = get_slot(tx_bits, 5); check("pcm_slot5", 64'(s), 64'(20'h5A5A0));
    s = get_slot(tx_bits, 6); check("pcm_slot6", 64'(s), 64'(20'h0));
    check("pcm_tags", 64'(get_slot0(tx_bits)), 64'(16'b1001_0100_0000_0000));
    $display("pcm frame checked");

    // Five commands into a four-entry FIFO.
    run_until(10);
    for (int i = 0; i < 5; i++) push_cmd(8'($urandom), 16'($urandom));
    run(256 * 6);
    $display("fifo overflow sequence done");

    // Random codec traffic, samples and commands.
    rand_codec = 1;
    for (int f = 0; f < 3; f++) begin
      run_until(100);
      out_data = {$urandom, $urandom};
      out_valid = 4'($urandom);
      push_cmd(8'($urandom), 16'($urandom));
      run_until(255);
    end
    run(256);
    rand_codec = 0;
    codec_bits = '0;
    $display("random traffic done");

    // Loopback: captured samples must match what was sent.
    loop_mode = 1;
    out_valid = 4'hF;
    run_until(0);
    chk_loop = 1;
    for (int f = 0; f < 3; f++) begin
      run_until(100);
      out_data = {$urandom, $urandom};
      if (f == 2) out_valid = 4'($urandom);
      run_until(200);
    end
    run_until(200);
    chk_loop = 0;
    loop_mode = 0;
    $display("loopback done");

    // Reset mid-frame with commands queued.
    begin
      int k;
      k = 0;
      while (q.size() != 0 && k < 2000) begin step(); k++; end
    end
    out_valid = 4'h0;
    run_until(20);
    for (int i = 0; i < 3; i++) push_cmd(8'($urandom_range(0, 127)), 16'($urandom));
    run_until(70);
    do_reset();
    run(512);
    check("post_rst_slot0", 64'(get_slot0(tx_bits)), 64'(16'h8000));
    check("post_rst_slot1", 64'(get_slot(tx_bits, 1)), 64'(20'h0));
    $display("reset mid-frame done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
